// File: rtl/pipe_scoreboard.sv
// In-flight destination scoreboard: detects RAW hazards, selects forwarding sources, stalls on unready loads.
// Optional stall statistics counter enabled by defining SCOREBOARD_STATS_EN.
module pipe_scoreboard #(
  parameter int unsigned DEPTH            = 3,
  parameter int unsigned REG_NUM_WIDTH    = 5,
  parameter int unsigned LOAD_READY_STAGE = 1,
  parameter int unsigned FLUSH_STAGES     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issueValid,
  input  logic                           issueWrEn,
  input  logic                           issueIsLoad,
  input  logic [REG_NUM_WIDTH-1:0]       issueDst,
  input  logic [REG_NUM_WIDTH-1:0]       srcA,
  input  logic [REG_NUM_WIDTH-1:0]       srcB,
  input  logic                           srcAUsed,
  input  logic                           srcBUsed,
  input  logic                           flush,
  output logic                           stall,
  output logic                           issueAccept,
  output logic [$clog2(DEPTH+1)-1:0]     fwdASel,
  output logic [$clog2(DEPTH+1)-1:0]     fwdBSel,
`ifdef SCOREBOARD_STATS_EN
  output logic [31:0]                    stallCycles,
`endif
  output logic [$clog2(DEPTH+1)-1:0]     inFlightCount
);

  localparam int unsigned SEL_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic             hold;
    logic [SEL_W-1:0] sel;
  } lookup_t;

  logic [DEPTH-1:0]         valid_q;
  logic [DEPTH-1:0]         valid_d;
  logic [DEPTH-1:0]         load_q;
  logic [REG_NUM_WIDTH-1:0] dst_q [DEPTH];
  logic [SEL_W-1:0]         count_q;
  lookup_t                  look_a;
  lookup_t                  look_b;

  // Scan oldest to youngest so the youngest matching stage is the one kept.
  function automatic lookup_t lookup(input logic [REG_NUM_WIDTH-1:0] src, input logic used);
    lookup_t     r;
    logic        hit;
    logic        hit_load;
    int unsigned hit_k;
    r        = '0;
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_k    = 0;
    for (int unsigned k = DEPTH; k > 0; k--) begin
      if (valid_q[k-1] && (dst_q[k-1] == src)) begin
        hit      = 1'b1;
        hit_load = load_q[k-1];
        hit_k    = k - 1;
      end
    end
    if (used && (src != '0) && hit) begin
      if (hit_load && (hit_k < LOAD_READY_STAGE)) r.hold = 1'b1;
      else                                        r.sel  = SEL_W'(hit_k + 1);
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] popcount(input logic [DEPTH-1:0] bits);
    int unsigned n;
    n = 0;
    for (int unsigned k = 0; k < DEPTH; k++) n += int'(bits[k]);
    return SEL_W'(n);
  endfunction

  always_comb begin
    look_a      = lookup(srcA, srcAUsed);
    look_b      = lookup(srcB, srcBUsed);
    stall       = look_a.hold | look_b.hold;
    fwdASel     = look_a.sel;
    fwdBSel     = look_b.sel;
    issueAccept = issueValid & ~stall & ~flush;
  end

  // Flush squashes the youngest stages by dropping them as they advance.
  always_comb begin
    valid_d    = '0;
    valid_d[0] = issueAccept & issueWrEn & (issueDst != '0);
    for (int unsigned k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1] & ~(flush & ((k - 1) < FLUSH_STAGES));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      load_q  <= '0;
      count_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) dst_q[k] <= '0;
    end else begin
      valid_q   <= valid_d;
      count_q   <= popcount(valid_d);
      dst_q[0]  <= issueDst;
      load_q[0] <= issueIsLoad;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        dst_q[k]  <= dst_q[k-1];
        load_q[k] <= load_q[k-1];
      end
    end
  end

  assign inFlightCount = count_q;

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCycles <= '0;
    end else if (stall && issueValid && (stallCycles != '1)) begin
      stallCycles <= stallCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard (DEPTH=3, LOAD_READY_STAGE=1, FLUSH_STAGES=1).
// Define SCOREBOARD_STATS_EN to also check the stall counter.
module tb_pipe_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issueValid, issueWrEn, issueIsLoad;
  logic [4:0] issueDst, srcA, srcB;
  logic       srcAUsed, srcBUsed, flush;
  logic       stall, issueAccept;
  logic [1:0] fwdASel, fwdBSel, inFlightCount;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stallCycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_scoreboard #(
    .DEPTH(3), .REG_NUM_WIDTH(5), .LOAD_READY_STAGE(1), .FLUSH_STAGES(1)
  ) dut (
    .clk(clk), .rst(rst),
    .issueValid(issueValid), .issueWrEn(issueWrEn), .issueIsLoad(issueIsLoad),
    .issueDst(issueDst), .srcA(srcA), .srcB(srcB),
    .srcAUsed(srcAUsed), .srcBUsed(srcBUsed), .flush(flush),
    .stall(stall), .issueAccept(issueAccept),
    .fwdASel(fwdASel), .fwdBSel(fwdBSel),
`ifdef SCOREBOARD_STATS_EN
    .stallCycles(stallCycles),
`endif
    .inFlightCount(inFlightCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic wr, input logic ld, input logic [4:0] d,
                        input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub,
                        input logic fl);
    issueValid  = v;
    issueWrEn   = wr;
    issueIsLoad = ld;
    issueDst    = d;
    srcA        = a;
    srcAUsed    = ua;
    srcB        = b;
    srcBUsed    = ub;
    flush       = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b0;
    set_in(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    repeat (2) tick();
    check("rst_count", 32'(inFlightCount), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_accept", 32'(issueAccept), 32'd1);
    @(negedge clk) rst = 1'b1;
    idle(1);

    // ALU write r3, then forward from EX and MEM
    set_in(1, 1, 0, 5'd3, 5'd0, 0, 5'd0, 0, 0); tick();
    set_in(1, 0, 0, 5'd0, 5'd3, 1, 5'd0, 0, 0); #1;
    check("alu_stall", 32'(stall), 32'd0);
    check("alu_fwdA_ex", 32'(fwdASel), 32'd1);
    check("alu_accept", 32'(issueAccept), 32'd1);
    tick(); #1;
    check("alu_fwdA_mem", 32'(fwdASel), 32'd2);
    idle(3);
    check("drain_count", 32'(inFlightCount), 32'd0);

    // load r5 used next cycle: one bubble, then forward from MEM
    set_in(1, 1, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0); tick();
    set_in(1, 0, 0, 5'd0, 5'd0, 0, 5'd5, 1, 0); #1;
    check("ld_stall", 32'(stall), 32'd1);
    check("ld_accept", 32'(issueAccept), 32'd0);
    tick(); #1;
    check("ld_stall_clr", 32'(stall), 32'd0);
    check("ld_fwdB", 32'(fwdBSel), 32'd2);
    check("ld_accept2", 32'(issueAccept), 32'd1);
    tick();
`ifdef SCOREBOARD_STATS_EN
    check("stall_cycles", stallCycles, 32'd1);
`endif
    idle(3);

    // r7 written twice: youngest wins
    set_in(1, 1, 0, 5'd7, 5'd0, 0, 5'd0, 0, 0); tick(); tick();
    set_in(1, 0, 0, 5'd0, 5'd7, 1, 5'd0, 0, 0); #1;
    check("yng_fwdA", 32'(fwdASel), 32'd1);
    check("yng_count", 32'(inFlightCount), 32'd2);
    check("yng_stall", 32'(stall), 32'd0);
    tick(); idle(3);

    // r0 never tracked
    set_in(1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0); tick();
    set_in(1, 0, 0, 5'd0, 5'd0, 1, 5'd0, 1, 0); #1;
    check("r0_fwdA", 32'(fwdASel), 32'd0);
    check("r0_fwdB", 32'(fwdBSel), 32'd0);
    check("r0_stall", 32'(stall), 32'd0);
    check("r0_count", 32'(inFlightCount), 32'd0);
    tick(); idle(3);

    // flush squashes stage 0 and blocks the issue in the flush cycle
    set_in(1, 1, 0, 5'd4, 5'd0, 0, 5'd0, 0, 0); tick();
    set_in(1, 1, 0, 5'd9, 5'd0, 0, 5'd0, 0, 1); #1;
    check("fl_accept", 32'(issueAccept), 32'd0);
    tick();
    set_in(1, 0, 0, 5'd0, 5'd4, 1, 5'd9, 1, 0); #1;
    check("fl_fwdA", 32'(fwdASel), 32'd0);
    check("fl_fwdB", 32'(fwdBSel), 32'd0);
    check("fl_count", 32'(inFlightCount), 32'd0);
    tick(); idle(3);

    // younger ALU r6 shadows older load r6
    set_in(1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0, 0); tick();
    set_in(1, 1, 0, 5'd6, 5'd0, 0, 5'd0, 0, 0); tick();
    set_in(1, 0, 0, 5'd0, 5'd6, 1, 5'd0, 0, 0); #1;
    check("shadow_stall", 32'(stall), 32'd0);
    check("shadow_fwdA", 32'(fwdASel), 32'd1);
    tick(); idle(3);

    // younger load r6 over older ALU r6 must stall
    set_in(1, 1, 0, 5'd6, 5'd0, 0, 5'd0, 0, 0); tick();
    set_in(1, 1, 1, 5'd6, 5'd0, 0, 5'd0, 0, 0); tick();
    set_in(1, 0, 0, 5'd0, 5'd0, 0, 5'd6, 1, 0); #1;
    check("ldyng_stall", 32'(stall), 32'd1);
    idle(3);

    // flush over stall: hazard visible, issue blocked, load squashed
    set_in(1, 1, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0); tick();
    set_in(1, 0, 0, 5'd0, 5'd0, 0, 5'd5, 1, 1); #1;
    check("fls_stall", 32'(stall), 32'd1);
    check("fls_accept", 32'(issueAccept), 32'd0);
    tick();
    set_in(1, 0, 0, 5'd0, 5'd0, 0, 5'd5, 1, 0); #1;
    check("fls_after_stall", 32'(stall), 32'd0);
    check("fls_after_fwdB", 32'(fwdBSel), 32'd0);
    idle(3);

    // asynchronous reset mid-operation
    set_in(1, 1, 1, 5'd5, 5'd0, 0, 5'd0, 0, 0); tick();
    set_in(1, 0, 0, 5'd0, 5'd5, 1, 5'd5, 1, 0); #1;
    check("pre_rst_stall", 32'(stall), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_fwdA", 32'(fwdASel), 32'd0);
    check("arst_fwdB", 32'(fwdBSel), 32'd0);
    check("arst_count", 32'(inFlightCount), 32'd0);
    check("arst_accept", 32'(issueAccept), 32'd1);
`ifdef SCOREBOARD_STATS_EN
    check("arst_stall_cycles", stallCycles, 32'd0);
`endif
    @(negedge clk) rst = 1'b1;
    set_in(1, 0, 0, 5'd0, 5'd5, 1, 5'd0, 0, 0); tick(); #1;
    check("post_rst_fwdA", 32'(fwdASel), 32'd0);
    check("post_rst_count", 32'(inFlightCount), 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3, number of tracked in-flight stages after issue (stage 0 = EX ... stage DEPTH-1 = WB).
REQ-002 SHALL have parameter REG_NUM_WIDTH, default 5, register-number width.
REQ-003 SHALL have parameter LOAD_READY_STAGE, default 1, first stage index from which load results are forwardable.
REQ-004 SHALL have parameter FLUSH_STAGES, default 1, count of youngest stages squashed by flush (1..DEPTH).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port issueValid  input  1  ID-stage instruction requests issue.
REQ-008 SHALL have port issueWrEn  input  1  issuing instruction writes a register.
REQ-009 SHALL have port issueIsLoad  input  1  issuing instruction is a load.
REQ-010 SHALL have port issueDst  input  REG_NUM_WIDTH  destination register.
REQ-011 SHALL have ports srcA, srcB  input  REG_NUM_WIDTH each  source registers.
REQ-012 SHALL have ports srcAUsed, srcBUsed  input  1 each  source operand actually read.
REQ-013 SHALL have port flush  input  1  branch/redirect squash request.
REQ-014 SHALL have port stall  output  1  ID must hold; bubble inserted.
REQ-015 SHALL have port issueAccept  output  1  instruction enters stage 0 this cycle.
REQ-016 SHALL have ports fwdASel, fwdBSel  output  ceil(log2(DEPTH+1)) each  0 = register file, k = forward from stage k-1.
REQ-017 SHALL have port inFlightCount  output  ceil(log2(DEPTH+1))  number of valid entries.

Function
REQ-018 SHALL hold DEPTH entries {valid, dst, isLoad}; every cycle entry k moves to k+1, entry DEPTH-1 retires; no hold state for entries.
REQ-019 SHALL load stage 0 with {1, issueDst, issueIsLoad} when issueAccept & issueWrEn & (issueDst != 0), else with a bubble (valid=0).
REQ-020 SHALL treat register 0 as never tracked: a source of 0 yields sel 0 and no stall.
REQ-021 SHALL, per used non-zero source, match against the youngest valid stage k with dst equal; younger match wins over older.
REQ-022 SHALL assert stall combinationally when the youngest match is a load with k < LOAD_READY_STAGE, for either source.
REQ-023 SHALL otherwise drive sel = k+1 for a match and sel = 0 for no match or unused source.
REQ-024 SHALL drive issueAccept = issueValid & ~stall & ~flush.
REQ-025 SHALL, when flush=1, invalidate at the next edge the entries currently in stages 0..FLUSH_STAGES-1 (they do not reach stages 1..FLUSH_STAGES) and load stage 0 with a bubble.
REQ-026 SHALL give flush priority over stall; stall output still reflects the hazard, issueAccept=0.
REQ-027 SHALL drive inFlightCount as the registered population count of valid bits.
REQ-028 SHALL have zero-cycle (combinational) latency from src/issue inputs to stall, fwd*Sel, issueAccept.

Reset
REQ-029 SHALL clear all entry valid bits immediately on rst=0, independent of clk.
REQ-030 SHALL drive during and after reset, with no valid entries: stall=0, fwdASel=0, fwdBSel=0, inFlightCount=0, issueAccept=issueValid & ~flush.
REQ-031 SHALL discard any in-flight entries when reset asserts mid-operation; first edge after rst release behaves as an empty scoreboard.

Configuration
REQ-032 SHALL, with SCOREBOARD_STATS_EN defined, add output stallCycles (32 bits), incremented on each clk edge where stall=1 & issueValid=1, saturating at 0xFFFFFFFF, cleared by reset.
REQ-033 SHALL, without SCOREBOARD_STATS_EN, omit stallCycles and its counter entirely; all other behaviour identical.

Verification (DEPTH=3, LOAD_READY_STAGE=1, FLUSH_STAGES=1)
REQ-034 SHALL cover: rst=0 with entries valid -> stall=0, fwdASel=fwdBSel=0, inFlightCount=0 immediately.
REQ-035 SHALL cover: issue ALU write r3, next cycle srcA=r3 used -> stall=0, fwdASel=1; following cycle -> fwdASel=2.
REQ-036 SHALL cover: issue load r5, next cycle srcB=r5 used -> stall=1, issueAccept=0 for one cycle, then stall=0, fwdBSel=2.
REQ-037 SHALL cover: write r7 two consecutive cycles, then read r7 -> fwdASel=1 (youngest), inFlightCount=2.
REQ-038 SHALL cover: write r0 then read r0 -> fwdASel=0, stall=0, inFlightCount=0.
REQ-039 SHALL cover: issue r4, flush=1 next cycle, then read r4 -> fwdASel=0, inFlightCount=0; with SCOREBOARD_STATS_EN, scenario REQ-036 -> stallCycles=1.
